// File: rtl/conv_11_7_1_pkg.sv
// Shared geometry, widths and FSM encoding for the 11x11 / 7x7 / stride-1
// convolution sequencer.
package conv_11_7_1_pkg;

    localparam int IN_DIM     = 11;
    localparam int K_DIM      = 7;
    localparam int OUT_DIM    = IN_DIM - K_DIM + 1;
    localparam int NPIX       = OUT_DIM * OUT_DIM;
    localparam int ACC_W_DFLT = 32;

    localparam int ROW_W   = $clog2(IN_DIM);
    localparam int COL_W   = ROW_W;
    localparam int KR_W    = $clog2(K_DIM);
    localparam int OCNT_W  = $clog2(OUT_DIM);
    localparam int OADDR_W = $clog2(NPIX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_OUTPUT,
        S_DONE
    } state_t;

endpackage

// File: rtl/conv_11_7_1_sched_if.sv
// Output pixel stream: signed result plus linear address, valid/ready handshake.
interface conv_11_7_1_sched_if #(
    parameter int ACC_W = 32
);
    import conv_11_7_1_pkg::*;

    logic signed [ACC_W-1:0] out_data;
    logic [OADDR_W-1:0]      out_addr;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output out_data,
        output out_addr,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_addr,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/conv_11_7_1_sched.sv
// Walks the 5x5 output grid, issues 7 kernel rows per pixel to the external
// MAC cell, accumulates the row partial sums and streams finished pixels.
module conv_11_7_1_sched
    import conv_11_7_1_pkg::*;
#(
    parameter int ACC_W = ACC_W_DFLT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [ROW_W-1:0]        row_addr,
    output logic [COL_W-1:0]        col_addr,
    output logic [KR_W-1:0]         k_row,
    output logic                    mac_en,
    input  logic signed [ACC_W-1:0] mac_result,
    conv_11_7_1_sched_if.master     out_if
);

    state_t                  state_q, state_d;
    logic [OCNT_W-1:0]       orow_q, orow_d;
    logic [OCNT_W-1:0]       ocol_q, ocol_d;
    logic [KR_W-1:0]         krow_q, krow_d;
    logic [ROW_W-1:0]        row_addr_q, row_addr_d;
    logic [COL_W-1:0]        col_addr_q, col_addr_d;
    logic                    mac_en_q, mac_en_d;
    logic                    en_d_q, en_d_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] out_data_q, out_data_d;
    logic [OADDR_W-1:0]      out_addr_q, out_addr_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [OCNT_W-1:0]       orow_nxt, ocol_nxt;
    logic                    last_pix;

    // Raster-order successor of the current output position.
    always_comb begin
        if (ocol_q == OCNT_W'(OUT_DIM - 1)) begin
            ocol_nxt = '0;
            orow_nxt = orow_q + OCNT_W'(1);
        end else begin
            ocol_nxt = ocol_q + OCNT_W'(1);
            orow_nxt = orow_q;
        end
        last_pix = (orow_q == OCNT_W'(OUT_DIM - 1)) && (ocol_q == OCNT_W'(OUT_DIM - 1));
    end

    always_comb begin
        state_d     = state_q;
        orow_d      = orow_q;
        ocol_d      = ocol_q;
        krow_d      = krow_q;
        row_addr_d  = row_addr_q;
        col_addr_d  = col_addr_q;
        mac_en_d    = mac_en_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        // MAC output lags its enable by one cycle, so accumulation follows en_d.
        en_d_d      = mac_en_q;
        acc_d       = en_d_q ? acc_q + mac_result : acc_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_ISSUE;
                    orow_d     = '0;
                    ocol_d     = '0;
                    krow_d     = '0;
                    row_addr_d = '0;
                    col_addr_d = '0;
                    mac_en_d   = 1'b1;
                    busy_d     = 1'b1;
                    acc_d      = '0;
                end
            end
            S_ISSUE: begin
                if (krow_q == KR_W'(K_DIM - 1)) begin
                    mac_en_d = 1'b0;
                    state_d  = S_DRAIN;
                end else begin
                    krow_d     = krow_q + KR_W'(1);
                    row_addr_d = ROW_W'(orow_q) + ROW_W'(krow_q) + ROW_W'(1);
                end
            end
            S_DRAIN: begin
                // acc_d already folds in the final row's partial sum.
                out_data_d  = acc_d;
                out_addr_d  = OADDR_W'(orow_q) * OADDR_W'(OUT_DIM) + OADDR_W'(ocol_q);
                out_valid_d = 1'b1;
                state_d     = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (out_if.out_ready) begin
                    out_valid_d = 1'b0;
                    if (last_pix) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        orow_d     = orow_nxt;
                        ocol_d     = ocol_nxt;
                        krow_d     = '0;
                        row_addr_d = ROW_W'(orow_nxt);
                        col_addr_d = COL_W'(ocol_nxt);
                        mac_en_d   = 1'b1;
                        acc_d      = '0;
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            orow_q      <= '0;
            ocol_q      <= '0;
            krow_q      <= '0;
            row_addr_q  <= '0;
            col_addr_q  <= '0;
            mac_en_q    <= 1'b0;
            en_d_q      <= 1'b0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            orow_q      <= orow_d;
            ocol_q      <= ocol_d;
            krow_q      <= krow_d;
            row_addr_q  <= row_addr_d;
            col_addr_q  <= col_addr_d;
            mac_en_q    <= mac_en_d;
            en_d_q      <= en_d_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign row_addr         = row_addr_q;
    assign col_addr         = col_addr_q;
    assign k_row            = krow_q;
    assign mac_en           = mac_en_q;
    assign out_if.out_data  = out_data_q;
    assign out_if.out_addr  = out_addr_q;
    assign out_if.out_valid = out_valid_q;

endmodule

// File: doc/conv_11_7_1_sched.md
Name: conv_11_7_1_sched

Overview:
Sequencer for the 7-tap signed MAC cell in the 11x11 input / 7x7 kernel / stride-1 convolution layer.
- Walks all 5x5 output positions. For each position it issues the 7 kernel rows to the MAC cell, one per cycle, and accumulates the 7 row partial sums.
- Presents each finished output pixel on a valid/ready interface with its linear address.
- Sits between the window/weight buffers (driven by its address outputs) and the next layer.

Parameters:
- IN_DIM, 11, input feature-map side length.
- K_DIM, 7, kernel side length; equals the MAC cell tap count.
- OUT_DIM, IN_DIM-K_DIM+1 (5), output side length; derived, not overridden.
- ACC_W, 32, accumulator, MAC-result and output width (signed).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a 25-pixel frame when idle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last pixel handshake.
- row_addr  out  4  input row of the 7-wide data window (orow+k_row).
- col_addr  out  4  leftmost input column of the window (ocol).
- k_row  out  3  kernel row index for the weight buffer (0..6).
- mac_en  out  1  enable to the MAC cell; the cell captures on the same edge that ends this cycle.
- mac_result  in  ACC_W  signed MAC cell output, valid the cycle after mac_en.
- out_data  out  ACC_W  signed convolution result.
- out_addr  out  5  linear output index, orow*OUT_DIM+ocol (0..24).
- out_valid  out  1  out_data/out_addr valid.
- out_ready  in  1  consumer accepts when out_valid&&out_ready.

Behaviour:
- Reset: clk is the only clock; rst is asynchronous, active-high. On rst, state=IDLE and all counters and accumulator clear. Every output resets to 0: busy, done, row_addr, col_addr, k_row, mac_en, out_data, out_addr, out_valid.
- All outputs are registered. Buffers are combinational on row_addr/col_addr/k_row, so the data for a given mac_en cycle is stable in that same cycle.
- FSM states: IDLE, ISSUE, DRAIN, OUTPUT, DONE.
- IDLE: start=1 -> ISSUE with orow=ocol=k_row=0; busy=1 next cycle.
- ISSUE (7 cycles): mac_en=1, row_addr=orow+k_row, col_addr=ocol, k_row counts 0..6. After k_row=6 -> DRAIN.
- Accumulate: en_d is mac_en delayed by one cycle. When en_d=1, acc <= acc+mac_result. acc is cleared on entry to the first ISSUE cycle of each pixel.
- DRAIN (1 cycle): mac_en=0; the last partial sum is added. Then -> OUTPUT, with out_data=final sum, out_addr=orow*5+ocol, out_valid=1.
- OUTPUT: hold out_valid, out_data and out_addr stable until out_ready=1. mac_en stays 0 and addresses hold.
- On handshake: out_valid=0. If the pixel is not the last, advance ocol (wrap 4->0 and increment orow) and go to ISSUE. After pixel 24 -> DONE.
- DONE (1 cycle): done=1, busy=0 in the same cycle -> IDLE.
- Timing: 9 cycles per pixel minimum (7 ISSUE + 1 DRAIN + 1 OUTPUT). With out_ready tied high, done is asserted 226 cycles after the start cycle.
- Arithmetic: two's-complement wrap at ACC_W. The worst case |49*128*128| = 802816 never overflows 32 bits.
- start while busy or in DONE: ignored.
- out_ready high outside OUTPUT: no effect.
- rst mid-frame: immediate return to IDLE with reset values. A partial frame is discarded and a new start restarts at pixel 0.
- Address bounds: row_addr never exceeds 10, col_addr never exceeds 4, k_row never exceeds 6.

Decomposition:
- Shared package conv_11_7_1_pkg: IN_DIM, K_DIM, OUT_DIM, address widths, and the state enumeration.
- Single module. Counters and FSM are small enough that no sub-module is warranted. The MAC cell is instantiated by the parent, not inside this block.

Test Plan:
- All data=1, all weights=1, out_ready=1, start pulse -> 25 outputs with out_data=49 and out_addr 0..24 in order; done 226 cycles after start; busy low afterwards.
- Address trace -> pixel 0: row_addr 0..6, col_addr 0, k_row 0..6. Pixel 5: row_addr 1..7, col_addr 0. Pixel 24: row_addr 4..10, col_addr 4.
- Data=-128, weights=-128 -> every out_data=802816. Data=-128, weights=127 -> every out_data=-796544.
- out_ready low for 10 cycles on pixel 3 -> out_valid held, out_data/out_addr stable, mac_en=0 throughout the stall; pixel 4 issue starts the cycle after the handshake.
- rst asserted during pixel 12 ISSUE -> all outputs 0 asynchronously. A later start produces a full frame from out_addr 0 with correct sums.
- start pulses while busy and in the DONE cycle -> ignored: exactly 25 outputs and one done pulse.
